update_scheduler: RTL and testbench
===================================

Name: update_scheduler

Overview:
Sequences the pixel_updater for the image generator. After reset it issues the display init cycle, then sweeps the full 16x16 cell grid with a clear object code. From then on it drains a small FIFO of cell-update requests posted by the drawing logic, issuing one en_update per request and waiting for cmd_done before issuing the next.

Parameters:
FIFO_DEPTH, 8, request FIFO entries (power of two, >=2)
CLEAR_CODE, 3'd0, obj_code used during the post-init clear sweep

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req_valid  input  1  drawing logic offers a cell update
req_x  input  4  cell column
req_y  input  4  cell row
req_obj  input  3  object code for the cell
req_ready  output  1  request accepted on a cycle where req_valid && req_ready
cmd_done  input  1  one-cycle pulse from pixel_updater: current command finished
init_cycle  output  1  one-cycle pulse that starts the display init sequence
en_update  output  1  one-cycle pulse that starts a single cell update
x  output  4  cell column to pixel_updater, held from pulse until cmd_done
y  output  4  cell row to pixel_updater, held from pulse until cmd_done
obj_code  output  3  object code to pixel_updater, held from pulse until cmd_done
init_done  output  1  high once init and clear sweep are complete
busy  output  1  high when a pixel_updater command is outstanding

Behaviour:
- Reset: all outputs are registered. Reset values: init_cycle=0, en_update=0, x=0, y=0, obj_code=0, init_done=0, busy=0. FIFO is flushed. State goes to INIT_ISSUE. req_ready=0 while rst=1.
- Reset asserted mid-operation aborts everything: the FIFO is flushed and the full init plus clear sequence restarts.
- States: INIT_ISSUE, INIT_WAIT, CLR_ISSUE, CLR_WAIT, IDLE, WAIT_DONE.
- INIT_ISSUE: on the first cycle after rst is released, init_cycle=1 for one cycle and busy=1; go to INIT_WAIT.
- INIT_WAIT: on cmd_done, load x=0, y=0 and go to CLR_ISSUE.
- CLR_ISSUE: en_update=1 for one cycle with obj_code=CLEAR_CODE; go to CLR_WAIT.
- CLR_WAIT: on cmd_done, advance the sweep in row-major order: x increments, and on x wrap 15->0, y increments. Return to CLR_ISSUE.
  - cmd_done for cell (15,15) instead sets init_done=1, busy=0 and goes to IDLE.
  - The sweep is exactly 256 en_update pulses.
- IDLE (only reachable with init_done=1): if the FIFO is non-empty, pop the head, register x/y/obj_code, pulse en_update, set busy=1 and go to WAIT_DONE. Otherwise stay in IDLE.
- WAIT_DONE: on cmd_done, clear busy and go to IDLE.
  - cmd_done is honoured in any *_WAIT / WAIT_DONE cycle, including the same cycle en_update is high.
  - cmd_done in IDLE is ignored.
- Latency:
  - Request accepted at cycle N into an empty FIFO while IDLE: en_update is high at cycle N+2.
  - cmd_done at cycle M with the FIFO non-empty: next en_update at M+2.
- FIFO:
  - req_ready = !full && !rst.
  - Requests are accepted during the init/clear phase but are not issued until init_done=1. Order is strictly FIFO.
  - A push and a pop in the same cycle are both performed, and count is unchanged. This includes the full case: a pop frees the slot the same cycle, but req_ready still reflects full for that cycle.
- x, y and obj_code change only on a pulse cycle. They hold their values until the next pulse.

Optional Feature:
Macro SCHED_COALESCE_EN.
- Defined: an incoming request whose (req_x, req_y) matches any entry still in the FIFO overwrites that entry's obj in place. No new entry is added and the match keeps its queue position.
  - req_ready = (!full || match) && !rst. This is a combinational path from req_x/req_y to req_ready.
  - Multiple matches cannot exist by construction.
  - The entry currently being issued has already been popped and is never matched.
- Not defined: no comparison logic. Every accepted request occupies a FIFO slot and duplicates are issued individually.

Test Plan:
- Reset then release: init_cycle pulses on the first cycle after release. After cmd_done (bench responds in 5 cycles), exactly 256 en_update pulses with obj_code=0 cover (0,0)..(15,15) row-major, then init_done=1.
- After init, push (3,7,obj=5): en_update high 2 cycles later with x=3, y=7, obj_code=5. busy=1 until cmd_done, and no further pulse before it.
- Push 8 requests while busy with FIFO_DEPTH=8: req_ready drops after the 8th. The 9th is held until the next pop and issued 9th in order. All 9 are issued in push order.
- Push 3 requests during the clear sweep: none are issued before init_done. They are then issued in order right after the sweep.
- Assert rst for 1 cycle while in WAIT_DONE with 4 queued: the FIFO is emptied, init_done=0, and init_cycle pulses again. The old requests are never issued.
- SCHED_COALESCE_EN: push (2,2,1), (4,4,3), (2,2,6) while busy: only 2 entries are queued. They are issued as (2,2,6) then (4,4,3).

Source files
------------

// File: rtl/update_scheduler.sv
// update_scheduler: sequences the pixel_updater. After reset it runs the
// display init cycle, sweeps all 16x16 cells with CLEAR_CODE, then drains
// a small request FIFO, one en_update per request, waiting for cmd_done.
// Optional feature: define SCHED_COALESCE_EN to merge a request into a
// queued entry for the same cell instead of taking a new slot.
module update_scheduler #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [2:0] CLEAR_CODE = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_x,
  input  logic [3:0] req_y,
  input  logic [2:0] req_obj,
  output logic       req_ready,
  input  logic       cmd_done,
  output logic       init_cycle,
  output logic       en_update,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [2:0] obj_code,
  output logic       init_done,
  output logic       busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    INIT_ISSUE,
    INIT_WAIT,
    CLR_ISSUE,
    CLR_WAIT,
    IDLE,
    WAIT_DONE
  } state_t;

  state_t state, state_next;

  logic [3:0]    fifo_x   [FIFO_DEPTH];
  logic [3:0]    fifo_y   [FIFO_DEPTH];
  logic [2:0]    fifo_obj [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, push_new;

  logic [7:0] sweep_idx, sweep_next;
  logic       init_cycle_next, en_update_next, init_done_next, busy_next;
  logic [3:0] x_next, y_next;
  logic [2:0] obj_next;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = (state == IDLE) && !empty;

`ifdef SCHED_COALESCE_EN
  logic          match, push_merge;
  logic [PW-1:0] match_idx, offset;

  // Look for a queued (not yet popped) entry addressing the same cell.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    offset    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if ((CW'(offset) < count) && !(pop && (offset == '0)) &&
          (fifo_x[i] == req_x) && (fifo_y[i] == req_y)) begin
        match     = 1'b1;
        match_idx = PW'(i);
      end
    end
  end

  assign req_ready  = (!full || match) && !rst;
  assign push_new   = req_valid && req_ready && !match;
  assign push_merge = req_valid && req_ready && match;
`else
  assign req_ready = !full && !rst;
  assign push_new  = req_valid && req_ready;
`endif

  // FIFO storage; only occupied slots are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_new) begin
      fifo_x[wr_ptr]   <= req_x;
      fifo_y[wr_ptr]   <= req_y;
      fifo_obj[wr_ptr] <= req_obj;
    end
`ifdef SCHED_COALESCE_EN
    if (push_merge) begin
      fifo_obj[match_idx] <= req_obj;
    end
`endif
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_new) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      case ({push_new, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Next-state and next-output logic; x/y/obj_code only move on a pulse.
  always_comb begin
    state_next      = state;
    init_cycle_next = 1'b0;
    en_update_next  = 1'b0;
    x_next          = x;
    y_next          = y;
    obj_next        = obj_code;
    init_done_next  = init_done;
    busy_next       = busy;
    sweep_next      = sweep_idx;
    case (state)
      INIT_ISSUE: begin
        init_cycle_next = 1'b1;
        busy_next       = 1'b1;
        state_next      = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (cmd_done) begin
          sweep_next = '0;
          state_next = CLR_ISSUE;
        end
      end
      CLR_ISSUE: begin
        en_update_next = 1'b1;
        x_next         = sweep_idx[3:0];
        y_next         = sweep_idx[7:4];
        obj_next       = CLEAR_CODE;
        state_next     = CLR_WAIT;
      end
      CLR_WAIT: begin
        if (cmd_done) begin
          if (sweep_idx == 8'hFF) begin
            init_done_next = 1'b1;
            busy_next      = 1'b0;
            state_next     = IDLE;
          end else begin
            sweep_next = sweep_idx + 8'd1;
            state_next = CLR_ISSUE;
          end
        end
      end
      IDLE: begin
        if (!empty) begin
          en_update_next = 1'b1;
          x_next         = fifo_x[rd_ptr];
          y_next         = fifo_y[rd_ptr];
          obj_next       = fifo_obj[rd_ptr];
          busy_next      = 1'b1;
          state_next     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (cmd_done) begin
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = INIT_ISSUE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT_ISSUE;
      init_cycle <= 1'b0;
      en_update  <= 1'b0;
      x          <= '0;
      y          <= '0;
      obj_code   <= '0;
      init_done  <= 1'b0;
      busy       <= 1'b0;
      sweep_idx  <= '0;
    end else begin
      state      <= state_next;
      init_cycle <= init_cycle_next;
      en_update  <= en_update_next;
      x          <= x_next;
      y          <= y_next;
      obj_code   <= obj_next;
      init_done  <= init_done_next;
      busy       <= busy_next;
      sweep_idx  <= sweep_next;
    end
  end

endmodule

// File: tb/tb_update_scheduler.sv
// tb_update_scheduler: self-checking bench for update_scheduler.
// A queue-based model of the scheduler is compared against the DUT on every
// cycle; directed scenarios add literal expectations. Build with
// SCHED_COALESCE_EN defined to include the coalescing scenario.
`timescale 1ns/1ps
module tb_update_scheduler;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [3:0] cx;
    logic [3:0] cy;
    logic [2:0] obj;
  } cell_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_x, req_y;
  logic [2:0] req_obj;
  logic       req_ready;
  logic       cmd_done;
  logic       init_cycle, en_update, init_done, busy;
  logic [3:0] x, y;
  logic [2:0] obj_code;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  cell_t mq[$];
  int    m_phase   = 0;
  bit    m_out     = 1'b0;
  bit    m_started = 1'b0;
  int    m_sweep   = 0;
  logic       exp_init = 1'b0, exp_en = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  logic [3:0] exp_x = '0, exp_y = '0;
  logic [2:0] exp_obj = '0;

  // cmd_done responder state
  int done_delay = 5;
  int done_timer = 0;
  bit saw_pulse, saw_rst;

  cell_t issue_log[$];

  update_scheduler #(.FIFO_DEPTH(DEPTH), .CLEAR_CODE(3'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_obj    (req_obj),
    .req_ready  (req_ready),
    .cmd_done   (cmd_done),
    .init_cycle (init_cycle),
    .en_update  (en_update),
    .x          (x),
    .y          (y),
    .obj_code   (obj_code),
    .init_done  (init_done),
    .busy       (busy)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scheduler model: compare this cycle's outputs, then advance one cycle.
  task automatic modelStep();
    bit    do_pop, match_hit, accept;
    int    match_i, k;
    cell_t head, req, tmp;
    req       = {req_x, req_y, req_obj};
    do_pop    = !rst && !m_out && (m_phase == 3) && (mq.size() > 0);
    match_hit = 1'b0;
    match_i   = 0;
`ifdef SCHED_COALESCE_EN
    for (int i = (do_pop ? 1 : 0); i < mq.size(); i++) begin
      if (mq[i].cx == req_x && mq[i].cy == req_y) begin
        match_hit = 1'b1;
        match_i   = i;
      end
    end
`endif
    accept = !rst && ((mq.size() < DEPTH) || match_hit);

    checkOutput("req_ready",  req_ready,  accept);
    checkOutput("init_cycle", init_cycle, exp_init);
    checkOutput("en_update",  en_update,  exp_en);
    checkOutput("x",          x,          exp_x);
    checkOutput("y",          y,          exp_y);
    checkOutput("obj_code",   obj_code,   exp_obj);
    checkOutput("busy",       busy,       exp_busy);
    checkOutput("init_done",  init_done,  exp_done);

    if (rst) begin
      mq.delete();
      m_phase = 0; m_out = 1'b0; m_started = 1'b0; m_sweep = 0;
      exp_init = 1'b0; exp_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
      exp_x = '0; exp_y = '0; exp_obj = '0;
    end else begin
      exp_init = 1'b0;
      exp_en   = 1'b0;
      if (!m_out) begin
        if (m_phase == 0) begin
          exp_init = 1'b1; m_out = 1'b1; m_phase = 1; m_started = 1'b1;
        end else if (m_phase == 2) begin
          exp_en  = 1'b1;
          exp_x   = 4'(m_sweep % 16);
          exp_y   = 4'(m_sweep / 16);
          exp_obj = 3'd0;
          m_sweep++;
          m_out = 1'b1;
        end else if (do_pop) begin
          head    = mq.pop_front();
          exp_en  = 1'b1;
          exp_x   = head.cx;
          exp_y   = head.cy;
          exp_obj = head.obj;
          m_out   = 1'b1;
        end
      end else if (cmd_done) begin
        m_out = 1'b0;
        if (m_phase == 1) begin
          m_phase = 2; m_sweep = 0;
        end else if (m_phase == 2 && m_sweep == 256) begin
          m_phase = 3;
        end
      end
      if (req_valid && accept) begin
        if (match_hit) begin
          k       = match_i - (do_pop ? 1 : 0);
          tmp     = mq[k];
          tmp.obj = req_obj;
          mq[k]   = tmp;
        end else begin
          mq.push_back(req);
        end
      end
      exp_busy = m_out || (m_started && m_phase != 3);
      exp_done = (m_phase == 3);
    end
  endtask

  // Single compare process: model vs DUT every cycle.
  always @(negedge clk) modelStep();

  // Record every en_update pulse for the directed order checks.
  always @(negedge clk) if (en_update === 1'b1) issue_log.push_back({x, y, obj_code});

  // pixel_updater stand-in: cmd_done done_delay cycles after each pulse.
  initial begin
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      saw_pulse = (init_cycle === 1'b1) || (en_update === 1'b1);
      saw_rst   = (rst === 1'b1);
      @(posedge clk); #1;
      cmd_done = 1'b0;
      if (saw_rst) begin
        done_timer = 0;
      end else begin
        if (done_timer > 0) begin
          done_timer--;
          if (done_timer == 0) cmd_done = 1'b1;
        end
        if (saw_pulse) done_timer = done_delay - 1;
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one request and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [3:0] px, input logic [3:0] py, input logic [2:0] po);
    int waited = 0;
    req_valid = 1'b1; req_x = px; req_y = py; req_obj = po;
    @(negedge clk);
    while (req_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("push_accepted", (waited < 400), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic waitInitDone(input int limit);
    int n = 0;
    while (init_done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("init_done_reached", init_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic waitIdle(input int limit);
    int n = 0;
    while ((mq.size() != 0 || busy !== 1'b0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", (n < limit), 1);
    @(posedge clk); #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; req_obj = '0;
    waitCycles(2);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_busy",      busy,      0);
    checkOutput("rst_ready",     req_ready, 0);

    // Reset release, init pulse, full clear sweep
    rst = 1'b0;
    waitCycles(1);
    checkOutput("init_pulse", init_cycle, 1);
    checkOutput("init_busy",  busy,       1);
    waitInitDone(3000);
    checkOutput("sweep_count", issue_log.size(), 256);
    checkOutput("sweep_first", issue_log[0],   {4'd0, 4'd0, 3'd0});
    checkOutput("sweep_17",    issue_log[17],  {4'd1, 4'd1, 3'd0});
    checkOutput("sweep_last",  issue_log[255], {4'd15, 4'd15, 3'd0});
    issue_log.delete();

    // Single request: pulse two cycles after acceptance
    applyStimulus(4'd3, 4'd7, 3'd5);
    waitCycles(1);
    checkOutput("single_en",   en_update, 1);
    checkOutput("single_x",    x,         3);
    checkOutput("single_y",    y,         7);
    checkOutput("single_obj",  obj_code,  5);
    checkOutput("single_busy", busy,      1);
    waitIdle(100);
    checkOutput("single_count", issue_log.size(), 1);
    issue_log.delete();

    // Fill the FIFO while a command is outstanding, ninth stalls
    done_delay = 30;
    applyStimulus(4'd0, 4'd1, 3'd1);
    waitCycles(1);
    checkOutput("burst_lead_en", en_update, 1);
    for (int i = 1; i <= 8; i++) applyStimulus(4'(i), 4'd2, 3'(i % 8));
    checkOutput("full_ready", req_ready, 0);
    applyStimulus(4'd9, 4'd2, 3'd1);
    waitIdle(1000);
    checkOutput("burst_count", issue_log.size(), 10);
    checkOutput("burst_lead", issue_log[0], {4'd0, 4'd1, 3'd1});
    for (int i = 1; i <= 9; i++) checkOutput("burst_order", issue_log[i], {4'(i), 4'd2, 3'(i % 8)});
    issue_log.delete();
    done_delay = 5;

    // Requests during clear sweep are held until init_done
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    issue_log.delete();
    waitCycles(20);
    applyStimulus(4'd5, 4'd5, 3'd2);
    applyStimulus(4'd6, 4'd6, 3'd3);
    applyStimulus(4'd7, 4'd7, 3'd4);
    checkOutput("sweep_not_done", init_done, 0);
    waitInitDone(3000);
    waitIdle(200);
    checkOutput("held_count", issue_log.size(), 259);
    checkOutput("held_0", issue_log[256], {4'd5, 4'd5, 3'd2});
    checkOutput("held_1", issue_log[257], {4'd6, 4'd6, 3'd3});
    checkOutput("held_2", issue_log[258], {4'd7, 4'd7, 3'd4});
    issue_log.delete();

    // Reset while waiting with four queued requests
    done_delay = 20;
    applyStimulus(4'd9, 4'd9, 3'd1);
    waitCycles(1);
    applyStimulus(4'd10, 4'd1, 3'd1);
    applyStimulus(4'd11, 4'd1, 3'd2);
    applyStimulus(4'd12, 4'd1, 3'd3);
    applyStimulus(4'd13, 4'd1, 3'd4);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    done_delay = 5;
    checkOutput("abort_init_done", init_done, 0);
    checkOutput("abort_busy",      busy,      0);
    issue_log.delete();
    waitCycles(1);
    checkOutput("abort_init_pulse", init_cycle, 1);
    waitInitDone(3000);
    waitCycles(30);
    checkOutput("abort_count", issue_log.size(), 256);
    checkOutput("abort_last",  issue_log[255], {4'd15, 4'd15, 3'd0});
    issue_log.delete();

`ifdef SCHED_COALESCE_EN
    // Same-cell requests merge into the queued entry
    done_delay = 30;
    applyStimulus(4'd1, 4'd1, 3'd7);
    waitCycles(1);
    applyStimulus(4'd2, 4'd2, 3'd1);
    applyStimulus(4'd4, 4'd4, 3'd3);
    applyStimulus(4'd2, 4'd2, 3'd6);
    waitIdle(500);
    checkOutput("merge_count", issue_log.size(), 3);
    checkOutput("merge_0", issue_log[1], {4'd2, 4'd2, 3'd6});
    checkOutput("merge_1", issue_log[2], {4'd4, 4'd4, 3'd3});
    issue_log.delete();
    done_delay = 5;
`endif

    waitCycles(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
